// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared constants and helpers for the multi-channel clock divider
package clkdiv_pkg;
    localparam int RST_PERIOD = 1;
    localparam int RST_HIGH = 1;
    function automatic int CH_IDX_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/clk_div_channel.sv
// clk_div_channel: one programmable divider channel with double-buffered period/high config
module clk_div_channel
    import clkdiv_pkg::*;
#(
    parameter int W = 32,
    parameter logic [W-1:0] DEF_P = W'(RST_PERIOD),
    parameter logic [W-1:0] DEF_H = W'(RST_HIGH)
) (
    input  logic         i_clk,
    input  logic         rst,
    input  logic         en,
    input  logic         sync,
    input  logic         wr,
    input  logic [W-1:0] wr_period,
    input  logic [W-1:0] wr_high,
    output logic         o_clk,
    output logic         o_tick,
    output logic         o_pending
);
    logic [W-1:0] cnt, act_p, act_h, sh_p, sh_h;
    logic [W-1:0] cnt_nx, act_p_nx, act_h_nx;
    logic run, pend, wrap, restart, apply;
    always_comb begin
        wrap     = cnt == act_p;
        restart  = !run || sync;
        apply    = pend && (!en || restart || wrap);
        act_p_nx = apply ? sh_p : act_p;
        act_h_nx = apply ? sh_h : act_h;
        cnt_nx   = (!en || restart || wrap) ? '0 : cnt + W'(1);
    end
    // a write on an applying edge lands in shadow and stays pending for the next boundary
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            run    <= 1'b0;
            act_p  <= DEF_P;
            act_h  <= DEF_H;
            sh_p   <= DEF_P;
            sh_h   <= DEF_H;
            pend   <= 1'b0;
            o_clk  <= 1'b0;
            o_tick <= 1'b0;
        end else begin
            cnt   <= cnt_nx;
            run   <= en;
            act_p <= act_p_nx;
            act_h <= act_h_nx;
            if (wr) begin
                sh_p <= wr_period;
                sh_h <= wr_high;
            end
            pend   <= wr || (pend && !apply);
            o_clk  <= en && (cnt_nx < act_h_nx);
            o_tick <= en && (cnt_nx == act_p_nx);
        end
    end
    assign o_pending = pend;
endmodule

// File: rtl/multi_clk_divider.sv
// multi_clk_divider: N-channel programmable clock divider with shared config port and sync
module multi_clk_divider
    import clkdiv_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int W = 32,
    parameter logic [W-1:0] DEF_PERIOD = W'(RST_PERIOD),
    parameter logic [W-1:0] DEF_HIGH = W'(RST_HIGH)
) (
    input  logic                          i_clk,
    input  logic                          rst,
    input  logic [N_CH-1:0]               ch_en,
    input  logic                          sync_start,
    input  logic                          cfg_wr,
    input  logic [CH_IDX_W(N_CH)-1:0]     cfg_ch,
    input  logic [W-1:0]                  cfg_period,
    input  logic [W-1:0]                  cfg_high,
    output logic [N_CH-1:0]               o_clk,
    output logic [N_CH-1:0]               o_tick,
    output logic [N_CH-1:0]               o_pending
);
    localparam int CH_W = CH_IDX_W(N_CH);
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        clk_div_channel #(
            .W     (W),
            .DEF_P (DEF_PERIOD),
            .DEF_H (DEF_HIGH)
        ) u_ch (
            .i_clk     (i_clk),
            .rst       (rst),
            .en        (ch_en[i]),
            .sync      (sync_start),
            .wr        (cfg_wr && cfg_ch == CH_W'(i)),
            .wr_period (cfg_period),
            .wr_high   (cfg_high),
            .o_clk     (o_clk[i]),
            .o_tick    (o_tick[i]),
            .o_pending (o_pending[i])
        );
    end
endmodule

// File: tb/tb_multi_clk_divider.sv
// tb_multi_clk_divider: directed self-checking bench for multi_clk_divider
module tb_multi_clk_divider;
    localparam int N = 3;
    localparam int W = 16;
    logic i_clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] ch_en = '0;
    logic sync_start = 1'b0;
    logic cfg_wr = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [W-1:0] cfg_period = '0;
    logic [W-1:0] cfg_high = '0;
    logic [N-1:0] o_clk, o_tick, o_pending;
    int vectors = 0;
    int errors = 0;

    multi_clk_divider #(.N_CH(N), .W(W), .DEF_PERIOD(16'd1), .DEF_HIGH(16'd1)) dut (
        .i_clk(i_clk), .rst(rst), .ch_en(ch_en), .sync_start(sync_start),
        .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_high(cfg_high),
        .o_clk(o_clk), .o_tick(o_tick), .o_pending(o_pending)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic write_cfg(input logic [1:0] ch, input logic [W-1:0] p, input logic [W-1:0] h);
        cfg_wr = 1'b1;
        cfg_ch = ch;
        cfg_period = p;
        cfg_high = h;
        step();
        cfg_wr = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] eclk, etick;
        eclk = 4'b1010;
        etick = 4'b0101;
        rst = 1'b1;
        step();
        step();
        vectors++;
        if ({o_clk, o_tick, o_pending} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got clk=%b tick=%b pend=%b exp all 0", o_clk, o_tick, o_pending);
        end
        rst = 1'b0;
        ch_en = 3'b001;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (o_clk[0] !== eclk[3-i] || o_tick[0] !== etick[3-i] || o_pending !== 3'b000) begin
                errors++;
                $display("FAIL reset_default cyc %0d got clk=%b tick=%b pend=%b exp clk=%b tick=%b pend=000",
                         i, o_clk[0], o_tick[0], o_pending, eclk[3-i], etick[3-i]);
            end
        end
    endtask

    task automatic test_odd_ratio();
        logic [9:0] eclk, etick;
        eclk = 10'b1100011000;
        etick = 10'b0000100001;
        ch_en = '0;
        write_cfg(2'd0, 16'd4, 16'd2);
        vectors++;
        if (o_pending !== 3'b001) begin
            errors++;
            $display("FAIL odd_pending_set got %b exp 001", o_pending);
        end
        step();
        vectors++;
        if (o_pending !== 3'b000) begin
            errors++;
            $display("FAIL odd_pending_apply_disabled got %b exp 000", o_pending);
        end
        ch_en = 3'b001;
        for (int i = 0; i < 10; i++) begin
            step();
            vectors++;
            if (o_clk[0] !== eclk[9-i] || o_tick[0] !== etick[9-i]) begin
                errors++;
                $display("FAIL odd_ratio cyc %0d got clk=%b tick=%b exp clk=%b tick=%b",
                         i, o_clk[0], o_tick[0], eclk[9-i], etick[9-i]);
            end
        end
    endtask

    task automatic test_shadow_update();
        logic [9:0] eclk, etick, epend;
        eclk = 10'b1001110001;
        etick = 10'b0010000010;
        epend = 10'b1110000000;
        ch_en = '0;
        write_cfg(2'd1, 16'd3, 16'd2);
        step();
        ch_en = 3'b010;
        step();
        write_cfg(2'd1, 16'd5, 16'd3);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step();
            vectors++;
            if (o_clk[1] !== eclk[9-i] || o_tick[1] !== etick[9-i] || o_pending[1] !== epend[9-i]) begin
                errors++;
                $display("FAIL shadow_update cyc %0d got clk=%b tick=%b pend=%b exp clk=%b tick=%b pend=%b",
                         i, o_clk[1], o_tick[1], o_pending[1], eclk[9-i], etick[9-i], epend[9-i]);
            end
        end
    endtask

    task automatic test_back_to_back_wrap_write();
        logic [10:0] eclk, etick, epend;
        eclk = 11'b10010000001;
        etick = 11'b00100000010;
        epend = 11'b11100000000;
        ch_en = '0;
        write_cfg(2'd2, 16'd2, 16'd1);
        step();
        ch_en = 3'b100;
        step();
        step();
        step();
        vectors++;
        if (o_tick[2] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_write_pre_tick got %b exp 1", o_tick[2]);
        end
        write_cfg(2'd2, 16'd6, 16'd1);
        for (int i = 0; i < 11; i++) begin
            if (i > 0) step();
            vectors++;
            if (o_clk[2] !== eclk[10-i] || o_tick[2] !== etick[10-i] || o_pending[2] !== epend[10-i]) begin
                errors++;
                $display("FAIL wrap_write cyc %0d got clk=%b tick=%b pend=%b exp clk=%b tick=%b pend=%b",
                         i, o_clk[2], o_tick[2], o_pending[2], eclk[10-i], etick[10-i], epend[10-i]);
            end
        end
    endtask

    task automatic test_edge_values();
        ch_en = '0;
        write_cfg(2'd0, 16'd3, 16'd0);
        write_cfg(2'd1, 16'd3, 16'd10);
        write_cfg(2'd2, 16'd0, 16'd1);
        step();
        vectors++;
        if (o_pending !== 3'b000) begin
            errors++;
            $display("FAIL edge_pending got %b exp 000", o_pending);
        end
        ch_en = 3'b111;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) write_cfg(2'd3, 16'd7, 16'd7);
            else step();
            vectors++;
            if (o_clk !== 3'b110 || o_tick[2] !== 1'b1 || o_pending !== 3'b000) begin
                errors++;
                $display("FAIL edge_values cyc %0d got clk=%b tick2=%b pend=%b exp clk=110 tick2=1 pend=000",
                         i, o_clk, o_tick[2], o_pending);
            end
        end
    endtask

    task automatic test_sync_reset();
        logic [2:0] eclk [5];
        logic [2:0] etick [5];
        eclk = '{3'b011, 3'b011, 3'b010, 3'b000, 3'b001};
        etick = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b000};
        ch_en = '0;
        write_cfg(2'd0, 16'd3, 16'd2);
        write_cfg(2'd1, 16'd5, 16'd3);
        step();
        ch_en = 3'b010;
        step();
        step();
        ch_en = 3'b011;
        step();
        step();
        step();
        vectors++;
        if (o_clk !== 3'b000) begin
            errors++;
            $display("FAIL sync_pre got clk=%b exp 000", o_clk);
        end
        sync_start = 1'b1;
        step();
        sync_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            vectors++;
            if (o_clk !== eclk[i] || o_tick !== etick[i]) begin
                errors++;
                $display("FAIL sync cyc %0d got clk=%b tick=%b exp clk=%b tick=%b",
                         i, o_clk, o_tick, eclk[i], etick[i]);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (o_clk !== 3'b000 || o_tick !== 3'b000 || o_pending !== 3'b000) begin
            errors++;
            $display("FAIL async_reset got clk=%b tick=%b pend=%b exp 000", o_clk, o_tick, o_pending);
        end
        step();
        rst = 1'b0;
        ch_en = '0;
    endtask

    initial begin
        test_reset();
        test_odd_ratio();
        test_shadow_update();
        test_back_to_back_wrap_write();
        test_edge_values();
        test_sync_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/multi_clk_divider.md
Name: multi_clk_divider

Overview:
- N-channel programmable clock divider that replaces the fixed even-ratio divider used in the pwm_driver timing path.
- Each channel has a runtime-programmable period and high time, so it supports odd ratios and arbitrary duty.
- Each channel outputs a registered divided-clock level and a one-cycle tick enable for downstream PWM/counter logic.
- Configuration writes are double-buffered and applied glitch-free at period boundaries; a global sync pulse phase-aligns all channels.

Parameters:
N_CH, 4, number of divider channels (1..16)
W, 32, width of period/high registers and counters
DEF_PERIOD, 1, reset value of every channel's period register P (period = P+1 cycles)
DEF_HIGH, 1, reset value of every channel's high register H

Ports:
i_clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
ch_en  input  N_CH  per-channel run enable
sync_start  input  1  single-cycle pulse; restarts all running channels at count 0
cfg_wr  input  1  config write strobe
cfg_ch  input  max(1,clog2(N_CH))  target channel of write
cfg_period  input  W  new P value
cfg_high  input  W  new H value
o_clk  output  N_CH  divided clock level per channel (registered)
o_tick  output  N_CH  one-cycle pulse in last cycle of each period (registered)
o_pending  output  N_CH  shadow config written but not yet applied

Behaviour:
- Reset (async, rst=1): cnt=0, run=0, active P/H and shadow P/H = DEF_PERIOD/DEF_HIGH, o_clk=0, o_tick=0, o_pending=0.
- Per channel, per edge:
  - ch_en=0: cnt<=0, run<=0, o_clk<=0, o_tick<=0. A pending shadow is copied to active immediately and pending clears.
  - ch_en=1, run=0 (first enabled edge): run<=1, cnt<=0; apply pending shadow.
  - run=1: cnt<=(cnt==P)?0:cnt+1. On wrap (cnt==P): active<=shadow if pending, pending clears.
  - Outputs are computed from post-edge cnt and post-edge active P/H: o_clk<=(cnt<H), o_tick<=(cnt==P).
- Latency and waveform: in the first enabled cycle o_clk=(H>0). o_clk is high for min(H,P+1) cycles, then low for the rest of the P+1 period. o_tick is high exactly once per period.
- H=0: o_clk constant 0. H>P: o_clk constant 1. P=0: o_tick constant 1 while enabled.
- No glitches: o_clk is a flop output, and active P/H change only at a wrap, enable, or sync.
- cfg_wr: shadow[cfg_ch]<={cfg_period,cfg_high}, pending<=1. Always accepted; a later write overwrites an unapplied earlier one.
- cfg_ch>=N_CH: the write is ignored.
- cfg_wr on the same cycle as the target channel's wrap: the wrap applies the old shadow; the new value lands in shadow with pending=1 and is applied at the next wrap.
- sync_start=1: every channel with run=1 gets cnt<=0 and applies pending, and outputs restart as in the first enabled cycle. Channels with ch_en=0 are unaffected.
- sync_start has priority over wrap; ch_en=0 has priority over sync_start.
- Reset mid-operation: all state returns to reset values asynchronously; outputs drop to 0 without waiting for an edge.
- Arithmetic: cnt is W bits unsigned, and comparisons are unsigned. P=2^W-1 is legal; cnt never exceeds P, so no overflow.

Decomposition:
- Shared package clkdiv_pkg holds the CH_IDX_W function (clog2 with minimum 1) and the reset-default constants.
- One sub-module, clk_div_channel: a single channel with counter, active/shadow registers, pending flag, and output flops.
- multi_clk_divider instantiates N_CH copies in a generate loop, decodes cfg_ch into per-channel write strobes, and fans out sync_start.

Test Plan:
- Reset defaults: hold rst, release, ch_en=1 -> P=1,H=1: o_clk 1,0,1,0...; o_tick 0,1,0,1...; o_pending=0.
- Odd ratio: write ch0 P=4,H=2 with ch_en[0]=0, then enable -> o_clk 1,1,0,0,0 repeating; o_tick on every 5th cycle.
- Shadow update: ch1 running P=3,H=2; write P=5,H=3 mid-period -> o_pending[1]=1 until wrap, old 1100 pattern completes, then 111000 pattern; no short pulse.
- Write coinciding with wrap: ch2 P=2; write P=6 on the cnt==2 cycle -> one more 3-cycle period, then 7-cycle periods.
- Edge values: H=0 gives o_clk=0; H=10,P=3 gives o_clk=1; P=0 gives o_tick=1 every cycle; cfg_ch=N_CH write changes nothing.
- Sync and reset: two channels P=3 and P=5 out of phase, then pulse sync_start -> both show o_clk rising on the next cycle with cnt=0. Assert rst between edges -> o_clk/o_tick go 0 immediately.
